fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined processor. It owns the program counter and drives the instruction-memory address.
- It captures the fetched instruction into the IF/ID pipeline register, together with its PC and PC+2.
- It handles stalls from the hazard unit, redirects from branch/jump resolution, a one-cycle boot bubble, and halt detection.
- It sits ahead of the decode stage and consumes redirect information from the execute stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per sequential fetch (16-bit instructions, byte addressed).
- HALT_OPCODE, 4'hF, value of inst[15:12] that identifies a halt instruction.
- NOP_INST, 16'h0000, instruction word placed in IF/ID as a bubble.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- first  input  1  synchronous, active-high reset; sampled on the rising edge of CLK.
- stall  input  1  hazard unit: hold PC and IF/ID this cycle.
- redirect_valid  input  1  branch taken / jump / return resolved this cycle.
- redirect_target  input  16  new PC for the redirect; bit 0 is forced to 0 internally.
- imem_data  input  16  instruction word at imem_addr, combinational same-cycle read.
- imem_addr  output  16  equals PC.
- ifid_inst  output  16  registered instruction to decode.
- ifid_pc  output  16  registered PC of ifid_inst.
- ifid_pc_plus  output  16  registered ifid_pc + PC_STEP, mod 2^16.
- ifid_valid  output  1  1 when ifid_inst is a real instruction; 0 for a bubble.
- halted  output  1  registered; 1 while the FSM is in HALTED.

Behaviour:
- Reset: first=1 at a CLK edge sets:
  - PC=RESET_PC, state=BOOT
  - ifid_inst=NOP_INST, ifid_pc=0, ifid_pc_plus=0, ifid_valid=0
  - halted=0
- Reset overrides every other input, in any state.
- State machine: BOOT, RUN, HALTED. All registered outputs are updated in the same edge.
- BOOT:
  - One cycle only.
  - IF/ID <= bubble (NOP_INST, valid 0).
  - PC holds.
  - Next state RUN.
  - stall and redirect are ignored in BOOT.
- RUN, priority redirect > stall > normal:
  - redirect_valid=1: PC <= {redirect_target[15:1],1'b0}; IF/ID <= bubble (wrong-path flush, also when stall=1); state stays RUN.
  - stall=1 (no redirect): PC and all IF/ID fields hold their values, including ifid_valid.
  - normal, non-halt instruction: IF/ID <= {imem_data, PC, PC+PC_STEP}, ifid_valid=1; PC <= PC+PC_STEP.
  - normal, halt instruction (imem_data[15:12]==HALT_OPCODE): IF/ID captures the halt instruction with ifid_valid=1; PC holds; state <= HALTED; halted=1 from the next edge.
- HALTED:
  - redirect_valid=1: PC <= target (bit 0 cleared); IF/ID <= bubble; state <= RUN; halted <= 0. This case is a halt fetched on a mispredicted path.
  - stall=1: IF/ID holds, so the halt instruction remains in decode.
  - otherwise: IF/ID <= bubble; PC holds.
  - PC never advances while in HALTED.
- Latency:
  - An instruction at PC appears on ifid_* at the edge ending the cycle in which imem_addr=PC.
  - A redirect takes effect on imem_addr one cycle after redirect_valid is sampled.
- Arithmetic:
  - PC+PC_STEP wraps modulo 2^16; 16'hFFFE+2 = 16'h0000.
  - ifid_pc_plus uses the same wrap.
- imem_addr is combinationally equal to the PC register. It is not affected by stall or redirect within the same cycle.

Test Plan:
- Reset and boot: assert first for 2 cycles, then release. Required response:
  - imem_addr=0000; ifid_valid=0 during the reset cycles and the BOOT cycle.
  - Sequential fetch of words A,B,C yields ifid_pc 0000,0002,0004 with ifid_pc_plus 0002,0004,0006 and valid=1.
- Stall: with PC=0006, hold stall=1 for 3 cycles. Required response:
  - imem_addr stays 0006 and ifid_* is unchanged.
  - On release, ifid_pc=0006 on the next edge.
- Redirect: redirect_valid=1 with target=0x0041 while stall=1. Required response:
  - Next edge gives PC=0x0040 and ifid_valid=0.
  - The following edge gives ifid_pc=0x0040.
- Halt: imem_data=0xF000 at PC=0010. Required response:
  - ifid_inst=F000 with valid=1, then halted=1.
  - Subsequent cycles give valid=0 with PC stuck at 0010.
  - A redirect to 0020 clears halted and resumes fetch at 0020.
- Wrap: RESET_PC=16'hFFFC, sequential fetch. Required response:
  - ifid_pc sequence FFFC, FFFE, 0000.
  - ifid_pc_plus for FFFE is 0000.
- Reset mid-run: assert first while in HALTED and with redirect_valid=1 at the same edge. Required response:
  - State BOOT, PC=RESET_PC, halted=0, ifid_valid=0.
  - The redirect is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and fills the IF/ID pipeline register. It also handles the one-cycle boot
// bubble, hazard stalls, branch/jump redirects and halt detection.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_STEP     = 16'd2,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INST    = 16'h0000
) (
  input  logic        CLK,
  input  logic        first,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] ifid_inst,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] ipc_q, ipc_d;
  logic [15:0] iplus_q, iplus_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [15:0] pc_next_seq;
  logic [15:0] redirect_pc;
  logic        is_halt;

  // Sequential next PC wraps naturally in 16 bits; redirect targets are
  // forced to halfword alignment.
  assign pc_next_seq = pc_q + PC_STEP;
  assign redirect_pc = {redirect_target[15:1], 1'b0};
  assign is_halt     = (imem_data[15:12] == HALT_OPCODE);

  // Next-state logic: redirect beats stall beats normal fetch.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    iplus_d = iplus_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_BOOT: begin
        // Memory output is not trusted on the first cycle out of reset.
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redirect_valid) begin
          // Whatever was fetched this cycle is on the wrong path.
          pc_d    = redirect_pc;
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end else if (!stall) begin
          inst_d  = imem_data;
          ipc_d   = pc_q;
          iplus_d = pc_next_seq;
          valid_d = 1'b1;
          if (is_halt) begin
            state_d = ST_HALTED;
          end else begin
            pc_d = pc_next_seq;
          end
        end
      end

      ST_HALTED: begin
        if (redirect_valid) begin
          // The halt was speculative; resume on the resolved path.
          pc_d    = redirect_pc;
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          state_d = ST_RUN;
        end else if (!stall) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    halted_d = (state_d == ST_HALTED);
  end

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (first) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      ipc_q    <= 16'h0000;
      iplus_q  <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      iplus_q  <= iplus_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_inst    = inst_q;
  assign ifid_pc      = ipc_q;
  assign ifid_pc_plus = iplus_q;
  assign ifid_valid   = valid_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. Two instances share the control inputs:
// one with the default reset PC, one starting at FFFC to exercise wrap.
// A reference model predicts the post-edge outputs, pushes them into a queue,
// and a separate monitor pops and compares them after every edge.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        first, stall, redirect_valid;
  logic [15:0] redirect_target;

  logic [15:0] imem_data_a, imem_addr_a, inst_a, pc_a, plus_a;
  logic        valid_a, halted_a;
  logic [15:0] imem_data_b, imem_addr_b, inst_b, pc_b, plus_b;
  logic        valid_b, halted_b;

  int checks   = 0;
  int failures = 0;

  // Instruction memory contents: a seeded scramble of the address that never
  // produces a halt opcode, except one planted F000 when enabled.
  logic [15:0] seed;
  bit          halt_en   = 1'b0;
  logic [15:0] halt_addr = 16'h0010;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    logic [15:0] w;
    if (halt_en && a == halt_addr) return 16'hF000;
    w = (a * 16'h9E37) ^ seed;
    if (w[15:12] == 4'hF) w[15:12] = 4'h7;
    return w;
  endfunction

  assign imem_data_a = mem_rd(imem_addr_a);
  assign imem_data_b = mem_rd(imem_addr_b);

  fetch_stage dut_a (
    .CLK(CLK), .first(first), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_data(imem_data_a), .imem_addr(imem_addr_a),
    .ifid_inst(inst_a), .ifid_pc(pc_a), .ifid_pc_plus(plus_a),
    .ifid_valid(valid_a), .halted(halted_a)
  );

  fetch_stage #(.RESET_PC(16'hFFFC)) dut_b (
    .CLK(CLK), .first(first), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_data(imem_data_b), .imem_addr(imem_addr_b),
    .ifid_inst(inst_b), .ifid_pc(pc_b), .ifid_pc_plus(plus_b),
    .ifid_valid(valid_b), .halted(halted_b)
  );

  always #5 CLK = ~CLK;

  // Architectural view of the stage, as seen after an edge.
  typedef struct packed {
    logic [15:0] pc;
    bit          booting;
    bit          stopped;
    logic [15:0] inst;
    logic [15:0] ipc;
    logic [15:0] iplus;
    bit          valid;
  } view_t;

  view_t m_a, m_b;
  view_t q_a[$];
  view_t q_b[$];

  // Reference rules for one clock edge.
  function automatic view_t step(input view_t m, input bit rst, input bit st,
                                 input bit rv, input logic [15:0] tgt,
                                 input logic [15:0] rpc);
    view_t n;
    logic [15:0] word;
    n    = m;
    word = mem_rd(m.pc);
    if (rst) begin
      n = '{pc: rpc, booting: 1'b1, stopped: 1'b0, inst: 16'h0000,
            ipc: 16'h0000, iplus: 16'h0000, valid: 1'b0};
    end else if (m.booting) begin
      n.booting = 1'b0;
      n.inst    = 16'h0000;
      n.valid   = 1'b0;
    end else if (rv) begin
      n.pc      = tgt & 16'hFFFE;
      n.inst    = 16'h0000;
      n.valid   = 1'b0;
      n.stopped = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (m.stopped) begin
      n.inst  = 16'h0000;
      n.valid = 1'b0;
    end else begin
      n.inst  = word;
      n.ipc   = m.pc;
      n.iplus = m.pc + 16'd2;
      n.valid = 1'b1;
      if (word[15:12] == 4'hF) n.stopped = 1'b1;
      else n.pc = m.pc + 16'd2;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input view_t e,
                         input logic [15:0] addr, input logic [15:0] inst,
                         input logic [15:0] ipc, input logic [15:0] iplus,
                         input logic valid, input logic hlt);
    check({tag, ".imem_addr"}, addr, e.pc);
    check({tag, ".halted"}, {15'd0, hlt}, {15'd0, e.stopped});
    check({tag, ".ifid_valid"}, {15'd0, valid}, {15'd0, e.valid});
    check({tag, ".ifid_inst"}, inst, e.inst);
    if (e.valid) begin
      check({tag, ".ifid_pc"}, ipc, e.ipc);
      check({tag, ".ifid_pc_plus"}, iplus, e.iplus);
    end
  endtask

  // Monitor: one expected record per edge, compared shortly after the edge.
  always begin
    view_t e;
    @(posedge CLK);
    #1;
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      compare("a", e, imem_addr_a, inst_a, pc_a, plus_a, valid_a, halted_a);
    end
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      compare("b", e, imem_addr_b, inst_b, pc_b, plus_b, valid_b, halted_b);
    end
  end

  // Apply inputs for one cycle and record the predicted outcome of the edge.
  task automatic tick(input bit rst, input bit st, input bit rv,
                      input logic [15:0] tgt);
    first = rst; stall = st; redirect_valid = rv; redirect_target = tgt;
    @(posedge CLK);
    m_a = step(m_a, rst, st, rv, tgt, 16'h0000);
    m_b = step(m_b, rst, st, rv, tgt, 16'hFFFC);
    q_a.push_back(m_a);
    q_b.push_back(m_b);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = 16'($urandom);
    first = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    m_a = '0;
    m_b = '0;
    @(negedge CLK);

    // Reset for two cycles, boot bubble, then three sequential fetches.
    tick(1, 0, 0, 16'h0000);
    tick(1, 0, 0, 16'h0000);
    check("reset.imem_addr", imem_addr_a, 16'h0000);
    tick(0, 0, 0, 16'h0000);
    check("boot.valid", {15'd0, valid_a}, 16'h0000);
    repeat (3) tick(0, 0, 0, 16'h0000);
    check("seq.ifid_pc", pc_a, 16'h0004);
    check("seq.ifid_pc_plus", plus_a, 16'h0006);
    check("wrap.ifid_pc", pc_b, 16'h0000);

    // Stall at PC 0006 for three cycles, then release.
    repeat (3) tick(0, 1, 0, 16'h0000);
    check("stall.imem_addr", imem_addr_a, 16'h0006);
    tick(0, 0, 0, 16'h0000);
    check("stall_release.ifid_pc", pc_a, 16'h0006);

    // Redirect to 0041 while stalled: PC 0040 and a bubble.
    tick(0, 1, 1, 16'h0041);
    check("redirect.imem_addr", imem_addr_a, 16'h0040);
    tick(0, 0, 0, 16'h0000);
    check("redirect.ifid_pc", pc_a, 16'h0040);

    // Halt at 0010, bubbles while halted, stall holds, redirect resumes.
    halt_en = 1'b1;
    halt_addr = 16'h0010;
    tick(0, 0, 1, 16'h0010);
    tick(0, 0, 0, 16'h0000);
    check("halt.ifid_inst", inst_a, 16'hF000);
    repeat (3) tick(0, 0, 0, 16'h0000);
    check("halt.pc_stuck", imem_addr_a, 16'h0010);
    tick(0, 1, 0, 16'h0000);
    tick(0, 0, 1, 16'h0020);
    check("halt_exit.halted", {15'd0, halted_a}, 16'h0000);
    repeat (2) tick(0, 0, 0, 16'h0000);

    // Reset while halted with a simultaneous redirect.
    tick(0, 0, 1, 16'h0010);
    repeat (2) tick(0, 0, 0, 16'h0000);
    tick(1, 0, 1, 16'h0080);
    check("midreset.imem_addr", imem_addr_a, 16'h0000);
    check("midreset.halted", {15'd0, halted_a}, 16'h0000);
    tick(0, 0, 0, 16'h0000);
    repeat (3) tick(0, 0, 0, 16'h0000);

    // Randomized traffic with a planted halt somewhere in the low region.
    halt_addr = {10'd0, 5'($urandom_range(0, 31)), 1'b0};
    for (int i = 0; i < 600; i++) begin
      bit r_rst, r_st, r_rv;
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 99) < 25);
      r_rv  = ($urandom_range(0, 99) < 12);
      tick(r_rst, r_st, r_rv, 16'($urandom_range(0, 16'h007F)));
    end
    tick(0, 0, 0, 16'h0000);

    check("drain.q_a", 16'(q_a.size()), 16'h0000);
    check("drain.q_b", 16'(q_b.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
